// File: rtl/stream_utils_pkg.sv
// Shared helpers for the stream_utils library blocks.
// Handshake: a word moves when valid && ready at a rising clk edge; valid never drops without a transfer.
package stream_utils_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_upsizer_slot.sv
// Single-entry output holding register with load/drain; 1-cycle load-to-valid latency.
// Accepts a load only when free (empty or draining this cycle), so contents stay stable under backpressure.
module stream_upsizer_slot #(
    parameter int DW = 48,
    parameter int KW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [KW-1:0] keep_i,
    input  logic          last_i,
    input  logic          ready_i,
    output logic          free_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [KW-1:0] keep_o,
    output logic          last_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        free_o  = !valid_q || ready_i;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/stream_upsizer.sv
// Packs DW_IN words into DW_IN*SCALE words, lane 0 in the LSBs; s_last_i flushes a partial word with a keep mask.
// Output valid the cycle after the closing accept; non-closing lanes keep filling while the output is stalled.
module stream_upsizer
    import stream_utils_pkg::*;
#(
    parameter int DW_IN = 16,
    parameter int SCALE = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DW_IN-1:0]          s_data_i,
    input  logic                      s_valid_i,
    input  logic                      s_last_i,
    output logic                      s_ready_o,
    output logic [DW_IN*SCALE-1:0]    m_data_o,
    output logic [SCALE-1:0]          m_keep_o,
    output logic                      m_last_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i
);

    localparam int              DW_OUT    = DW_IN * SCALE;
    localparam int              CW        = clog2(SCALE);
    localparam logic [CW-1:0]   LAST_LANE = CW'(SCALE - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW_OUT-1:0] pack_q, pack_d, word;
    logic [SCALE-1:0]  keep_q, keep_d, word_keep;
    logic              slot_free, closing, accept, load;

    always_comb begin
        closing   = (cnt_q == LAST_LANE) || s_last_i;
        // m_ready_i reaches s_ready_o combinationally through slot_free.
        s_ready_o = !rst && (slot_free || !closing);
        accept    = s_valid_i && s_ready_o;
        load      = accept && closing;

        word = pack_q;
        word[cnt_q*DW_IN +: DW_IN] = s_data_i;
        word_keep = keep_q | (SCALE'(1) << cnt_q);

        cnt_d  = cnt_q;
        pack_d = pack_q;
        keep_d = keep_q;
        if (load) begin
            cnt_d  = '0;
            pack_d = '0;
            keep_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            pack_d = word;
            keep_d = word_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pack_q <= '0;
            keep_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            keep_q <= keep_d;
        end
    end

    stream_upsizer_slot #(
        .DW (DW_OUT),
        .KW (SCALE)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (word),
        .keep_i  (word_keep),
        .last_i  (s_last_i),
        .ready_i (m_ready_i),
        .free_o  (slot_free),
        .valid_o (m_valid_o),
        .data_o  (m_data_o),
        .keep_o  (m_keep_o),
        .last_o  (m_last_o)
    );

endmodule
